// File: rtl/flopoco_pkg.sv
// Shared definitions for FloPoCo-format float blocks: word geometry,
// exception encodings and the reduction controller's state type.
package flopoco_pkg;

    localparam int WE = 4;
    localparam int WF = 10;
    localparam int W  = WE + WF + 3;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [W-1:0] CANON_NAN = {EXC_NAN, {(W-2){1'b0}}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/fcmplt.sv
// Combinational strict less-than for FloPoCo floats; any NaN operand makes
// the pair unordered and forces XltY low.
module fcmplt
    import flopoco_pkg::*;
#(
    parameter int WE = 4,
    parameter int WF = 10
) (
    input  logic [WE+WF+2:0] X,
    input  logic [WE+WF+2:0] Y,
    output logic             XltY,
    output logic             unordered
);

    localparam int CW = WE + WF + 3;

    logic [1:0]       exc_x, exc_y;
    logic             sgn_x, sgn_y;
    logic [WE+WF+1:0] mag_x, mag_y;
    logic             both_zero;
    logic             lt;

    assign exc_x = X[CW-1:CW-2];
    assign exc_y = Y[CW-1:CW-2];
    assign sgn_x = X[CW-3];
    assign sgn_y = Y[CW-3];

    // Exception code in the top bits orders zero < normal < inf by magnitude;
    // payload bits of zero/inf are ignored.
    assign mag_x = {exc_x, (exc_x == EXC_NORMAL) ? X[WE+WF-1:0] : {(WE+WF){1'b0}}};
    assign mag_y = {exc_y, (exc_y == EXC_NORMAL) ? Y[WE+WF-1:0] : {(WE+WF){1'b0}}};
    assign both_zero = (exc_x == EXC_ZERO) && (exc_y == EXC_ZERO);

    always_comb begin
        lt = 1'b0;
        unique case ({sgn_x, sgn_y})
            2'b00: lt = mag_x < mag_y;
            2'b11: lt = mag_x > mag_y;
            2'b10: lt = !both_zero;
            2'b01: lt = 1'b0;
            default: lt = 1'b0;
        endcase
    end

    assign unordered = (exc_x == EXC_NAN) || (exc_y == EXC_NAN);
    assign XltY      = lt && !unordered;

endmodule

// File: rtl/fmax_reduce.sv
// Streaming max/argmax reduction over FloPoCo floats. One operand per cycle;
// the result {max, idx, nan, ovf} is held after the element marked in_last.
module fmax_reduce
    import flopoco_pkg::*;
#(
    parameter int WE   = 4,
    parameter int WF   = 10,
    parameter int IDXW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WE+WF+2:0]    in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WE+WF+2:0]    out_max,
    output logic [IDXW-1:0]     out_idx,
    output logic                out_nan,
    output logic                out_ovf
);

    localparam int RW = WE + WF + 3;
    localparam logic [RW-1:0] NAN_WORD = {EXC_NAN, {(RW-2){1'b0}}};

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready depends only on state and rst, out_valid only on state.
    state_e          state_q, state_d;
    logic [RW-1:0]   max_q, max_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic            nan_q, nan_d;
    logic            ovf_q, ovf_d;
    logic [RW-1:0]   out_max_q, out_max_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic            out_nan_q, out_nan_d;
    logic            out_ovf_q, out_ovf_d;

    logic accept, x_nan, have_num, cmp_lt, cmp_unord, update;

    fcmplt #(.WE(WE), .WF(WF)) u_cmp (
        .X         (max_q),
        .Y         (in_data),
        .XltY      (cmp_lt),
        .unordered (cmp_unord)
    );

    assign in_ready  = (state_q != ST_HOLD) && !rst;
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign x_nan     = (in_data[RW-1:RW-2] == EXC_NAN);
    assign have_num  = (state_q == ST_ACCUM);
    // The held max is never NaN, so unordered only repeats the local NaN test.
    assign update    = !x_nan && !cmp_unord && (!have_num || cmp_lt);

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        nan_d     = nan_q;
        ovf_d     = ovf_q;
        out_max_d = out_max_q;
        out_idx_d = out_idx_q;
        out_nan_d = out_nan_q;
        out_ovf_d = out_ovf_q;
        unique case (state_q)
            ST_EMPTY, ST_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    nan_d = nan_q | x_nan;
                    if (cnt_q == {IDXW{1'b1}}) ovf_d = 1'b1;
                    if (update) begin
                        max_d   = in_data;
                        idx_d   = cnt_q;
                        state_d = ST_ACCUM;
                    end
                    if (in_last) begin
                        out_max_d = update ? in_data : (have_num ? max_q : NAN_WORD);
                        out_idx_d = update ? cnt_q : (have_num ? idx_q : {IDXW{1'b0}});
                        out_nan_d = nan_q | x_nan;
                        out_ovf_d = ovf_q;
                        cnt_d     = '0;
                        nan_d     = 1'b0;
                        ovf_d     = 1'b0;
                        max_d     = '0;
                        idx_d     = '0;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            max_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            nan_q     <= 1'b0;
            ovf_q     <= 1'b0;
            out_max_q <= '0;
            out_idx_q <= '0;
            out_nan_q <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            nan_q     <= nan_d;
            ovf_q     <= ovf_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
            out_nan_q <= out_nan_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_max = out_max_q;
    assign out_idx = out_idx_q;
    assign out_nan = out_nan_q;
    assign out_ovf = out_ovf_q;

endmodule
